// File: rtl/mul32_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul32_seq_pkg
// Shared definitions for the sequential 32x32 multiplier: datapath width,
// number of shift-add iterations, the controller state encoding and a small
// helper that produces operand magnitudes.
// -----------------------------------------------------------------------------
package mul32_seq_pkg;

  localparam int XLEN       = 32;
  localparam int CALC_STEPS = 32;
  localparam int CNT_W      = $clog2(CALC_STEPS);

  // Index of the final shift-add step; the controller leaves CALC after it.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(CALC_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    NEG_LO = 3'd2,
    NEG_HI = 3'd3,
    FIN    = 3'd4
  } state_e;

  // Magnitude of an operand. In signed mode a negative value is negated with
  // ~x+1; the most negative value maps onto itself, which read as unsigned is
  // exactly its magnitude, so no special case is needed.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x,
                                               input logic            is_signed);
    if (is_signed && x[XLEN-1]) begin
      return ~x + 1'b1;
    end
    return x;
  endfunction

endpackage

// File: rtl/mul32_seq_cla32.sv
// -----------------------------------------------------------------------------
// cla32
// 32-bit carry-lookahead adder built from 4-bit lookahead groups whose
// group carries are chained.
// Ports:
//   a, b   : addends
//   c_in   : carry into bit 0
//   sum    : a + b + c_in, low 32 bits
//   c_out  : carry out of bit 31
// -----------------------------------------------------------------------------
module cla32
  import mul32_seq_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            c_in,
  output logic [XLEN-1:0] sum,
  output logic            c_out
);

  logic [XLEN-1:0] gen;
  logic [XLEN-1:0] prop;
  logic [XLEN:0]   carry;

  // Carries are computed inside a function so the group-to-group chain lives
  // in local variables rather than in a self-referencing signal vector.
  function automatic logic [XLEN:0] lookahead(input logic [XLEN-1:0] g,
                                              input logic [XLEN-1:0] p,
                                              input logic            cin);
    logic [XLEN:0] c;
    int            b0;
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < XLEN / 4; k++) begin
      b0 = 4 * k;
      c[b0+1] = g[b0] | (p[b0] & c[b0]);
      c[b0+2] = g[b0+1] | (p[b0+1] & g[b0]) | (p[b0+1] & p[b0] & c[b0]);
      c[b0+3] = g[b0+2] | (p[b0+2] & g[b0+1]) | (p[b0+2] & p[b0+1] & g[b0])
              | (p[b0+2] & p[b0+1] & p[b0] & c[b0]);
      c[b0+4] = g[b0+3] | (p[b0+3] & g[b0+2]) | (p[b0+3] & p[b0+2] & g[b0+1])
              | (p[b0+3] & p[b0+2] & p[b0+1] & g[b0])
              | (p[b0+3] & p[b0+2] & p[b0+1] & p[b0] & c[b0]);
    end
    return c;
  endfunction

  // Bitwise generate/propagate, lookahead carries, then the sum bits.
  always_comb begin
    gen   = a & b;
    prop  = a ^ b;
    carry = lookahead(gen, prop, c_in);
    sum   = prop ^ carry[XLEN-1:0];
    c_out = carry[XLEN];
  end

endmodule

// File: rtl/mul32_seq.sv
// -----------------------------------------------------------------------------
// mul32_seq
// Sequential radix-2 shift-add multiplier, signed or unsigned 32x32 -> 64.
// Magnitudes are multiplied over 32 CALC cycles; a negative result is then
// two's-complemented in two more cycles (low word, then high word), all
// through one shared cla32 instance.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, accepted in IDLE or FIN
//   is_signed       : operand interpretation, sampled with start
//   op_a, op_b      : multiplicand / multiplier, sampled with start
//   busy            : high in CALC, NEG_LO, NEG_HI
//   done            : one-cycle pulse in FIN, product valid
//   product         : registered 64-bit result, held until the next one
// -----------------------------------------------------------------------------
module mul32_seq
  import mul32_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  state_e            state_q,   state_d;
  logic [XLEN-1:0]   mcand_q,   mcand_d;
  logic [XLEN-1:0]   acc_hi_q,  acc_hi_d;
  logic [XLEN-1:0]   acc_lo_q,  acc_lo_d;
  logic              carry_q,   carry_d;
  logic              neg_q,     neg_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [2*XLEN-1:0] product_q, product_d;

  logic [XLEN-1:0]   add_a;
  logic [XLEN-1:0]   add_b;
  logic              add_cin;
  logic [XLEN-1:0]   add_sum;
  logic              add_cout;
  logic              accept;

  // Adder operand select: accumulate the multiplicand in CALC, and form
  // ~x + carry for the two halves of the final negation.
  always_comb begin
    add_a   = acc_hi_q;
    add_b   = mcand_q;
    add_cin = 1'b0;
    case (state_q)
      NEG_LO: begin
        add_a   = ~acc_lo_q;
        add_b   = '0;
        add_cin = 1'b1;
      end
      NEG_HI: begin
        add_a   = ~acc_hi_q;
        add_b   = '0;
        add_cin = carry_q;
      end
      default: ;
    endcase
  end

  cla32 u_cla32 (
    .a     (add_a),
    .b     (add_b),
    .c_in  (add_cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // Next-state and datapath update. A new request is only honoured from IDLE
  // or FIN and overrides whatever the case statement decided.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    carry_d   = carry_q;
    neg_d     = neg_q;
    count_d   = count_q;
    product_d = product_q;
    accept    = start && (state_q == IDLE || state_q == FIN);

    case (state_q)
      CALC: begin
        if (acc_lo_q[0]) begin
          acc_hi_d = {add_cout, add_sum[XLEN-1:1]};
          acc_lo_d = {add_sum[0], acc_lo_q[XLEN-1:1]};
        end else begin
          acc_hi_d = {1'b0, acc_hi_q[XLEN-1:1]};
          acc_lo_d = {acc_hi_q[0], acc_lo_q[XLEN-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          if (neg_q) begin
            state_d = NEG_LO;
          end else begin
            state_d   = FIN;
            product_d = {acc_hi_d, acc_lo_d};
          end
        end
      end
      NEG_LO: begin
        acc_lo_d = add_sum;
        carry_d  = add_cout;
        state_d  = NEG_HI;
      end
      NEG_HI: begin
        acc_hi_d  = add_sum;
        state_d   = FIN;
        product_d = {add_sum, acc_lo_q};
      end
      FIN: begin
        state_d = IDLE;
      end
      default: ;
    endcase

    // A zero operand gives a zero product, so the sign fix-up is skipped.
    if (accept) begin
      mcand_d  = abs_val(op_a, is_signed);
      acc_lo_d = abs_val(op_b, is_signed);
      acc_hi_d = '0;
      carry_d  = 1'b0;
      count_d  = '0;
      neg_d    = is_signed && (op_a[XLEN-1] ^ op_b[XLEN-1])
                 && (op_a != '0) && (op_b != '0);
      state_d  = CALC;
    end
  end

  // State register with synchronous reset that also aborts a running multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      carry_q   <= 1'b0;
      neg_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      carry_q   <= carry_d;
      neg_q     <= neg_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC) || (state_q == NEG_LO) || (state_q == NEG_HI);
  assign done    = (state_q == FIN);
  assign product = product_q;

endmodule

// File: tb/tb_mul32_seq.sv
// -----------------------------------------------------------------------------
// tb_mul32_seq
// Directed-vector bench for mul32_seq: a table of hand-computed products and
// latencies, hand-written sequences for back-to-back, ignored start and reset
// abort, and a short run of random operands against a 64-bit reference.
// -----------------------------------------------------------------------------
module tb_mul32_seq;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int   checkCount;
  int   failCount;
  vec_t vecs[14];

  mul32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: bump the count and report any difference.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
    end
  endtask

  // Present a request for exactly one rising edge, then drop start.
  task automatic startOp(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    is_signed = sgn;
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges (including the accepting one) until done is seen; bounded.
  task automatic waitDone(input int startLat, output int lat);
    lat = startLat;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, output int lat);
    startOp(sgn, a, b);
    waitDone(1, lat);
  endtask

  function automatic logic [63:0] refMul(input logic sgn, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    sp = sa * sb;
    return sp;
  endfunction

  function automatic int refLat(input logic sgn, input logic [31:0] a,
                                input logic [31:0] b);
    if (sgn && (a[31] ^ b[31]) && a != 32'd0 && b != 32'd0) return 35;
    return 33;
  endfunction

  initial begin
    int lat;
    int doneSeen;
    logic        rs;
    logic [31:0] ra;
    logic [31:0] rb;

    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    start      = 1'b0;
    is_signed  = 1'b0;
    op_a       = '0;
    op_b       = '0;

    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 35};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 33};
    vecs[3]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 33};
    vecs[4]  = '{1'b0, 32'h00000007, 32'h00000006, 64'h00000000_0000002A, 33};
    vecs[5]  = '{1'b1, 32'h00000000, 32'hFFFFFFFB, 64'h00000000_00000000, 33};
    vecs[6]  = '{1'b0, 32'h00000000, 32'h00000000, 64'h00000000_00000000, 33};
    vecs[7]  = '{1'b1, 32'h00000007, 32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6, 35};
    vecs[8]  = '{1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000, 33};
    vecs[9]  = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000, 35};
    vecs[10] = '{1'b0, 32'h12345678, 32'h00000010, 64'h00000001_23456780, 33};
    vecs[11] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 33};
    vecs[12] = '{1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 33};
    vecs[13] = '{1'b0, 32'hFFFFFFFD, 32'h00000005, 64'h00000004_FFFFFFF1, 33};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset product", product, 64'd0);
    rst = 1'b0;

    // Table vectors; the first start lands on the first edge after reset.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("vec%0d product", i), product, vecs[i].prod);
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d done one cycle", i), 64'(done), 64'd0);
    end

    // Back-to-back: new request issued in the FIN cycle.
    $display("[TB] back-to-back sequence");
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    checkOutput("b2b first product", product, 64'hFFFFFFFE_00000001);
    startOp(1'b0, 32'd7, 32'd6);
    checkOutput("b2b busy", 64'(busy), 64'd1);
    checkOutput("b2b product held", product, 64'hFFFFFFFE_00000001);
    waitDone(1, lat);
    checkOutput("b2b second latency", 64'(lat), 64'd33);
    checkOutput("b2b second product", product, 64'd42);
    @(posedge clk);
    #1;

    // Start pulsed while busy at count 10 must be ignored.
    $display("[TB] ignored start sequence");
    startOp(1'b1, 32'hFFFFFFFD, 32'h00000005);
    repeat (10) @(posedge clk);
    #1;
    is_signed = 1'b0;
    op_a      = 32'd7;
    op_b      = 32'd6;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(12, lat);
    checkOutput("ignore latency", 64'(lat), 64'd35);
    checkOutput("ignore product", product, 64'hFFFFFFFF_FFFFFFF1);
    @(posedge clk);
    #1;

    // Reset at count 20 aborts without a done pulse.
    $display("[TB] reset abort sequence");
    startOp(1'b0, 32'h00001234, 32'h00005678);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort product", product, 64'd0);
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("abort no done", 64'(doneSeen), 64'd0);

    // Random operands against the reference model.
    $display("[TB] random sequence");
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) ra = 32'h80000000;
      if (i % 15 == 0) rb = 32'h00000000;
      applyStimulus(rs, ra, rb, lat);
      checkOutput($sformatf("rand%0d product", i), product, refMul(rs, ra, rb));
      checkOutput($sformatf("rand%0d latency", i), 64'(lat), 64'(refLat(rs, ra, rb)));
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mul32_seq.md
MUL32_SEQ -- requirements
Module: mul32_seq

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 start  in  1  request a multiply; sampled only when the block is idle or in its done cycle.
REQ-004 is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-005 op_a  in  32  multiplicand; sampled with start.
REQ-006 op_b  in  32  multiplier; sampled with start.
REQ-007 busy  out  1  high while a multiply is in progress (CALC, NEG_LO, NEG_HI).
REQ-008 done  out  1  single-cycle pulse; product is valid in this cycle.
REQ-009 product  out  64  registered result; holds its value until the next accepted start completes.

Function
REQ-010 States SHALL be IDLE, CALC, NEG_LO, NEG_HI and FIN; done=1 only in FIN; busy=1 only in CALC, NEG_LO and NEG_HI.
REQ-011 On an edge with start=1 in IDLE or FIN, the block SHALL latch |op_a| as mcand, |op_b| into acc_lo, and set acc_hi=0, carry=0, count=0.
REQ-012 In signed mode, absolute values SHALL be taken as ~x+1; 0x80000000 maps to unsigned 0x80000000.
REQ-013 On the same edge, the block SHALL latch neg_flag = is_signed & (op_a[31] ^ op_b[31]) and enter CALC.
REQ-014 Each CALC edge SHALL perform one radix-2 step: if acc_lo[0]=1, then {acc_hi,acc_lo} <= {cout, sum, acc_lo[31:1]}, where {cout,sum} = acc_hi + mcand with c_in=0.
REQ-015 If acc_lo[0]=0, the CALC step SHALL be {acc_hi,acc_lo} <= {1'b0, acc_hi, acc_lo[31:1]}.
REQ-016 CALC SHALL last exactly 32 edges (count 0..31); after the 32nd edge the block SHALL go to NEG_LO if neg_flag=1, else to FIN.
REQ-017 In NEG_LO, acc_lo SHALL become ~acc_lo + 1 through the shared adder, and the carry-out SHALL be saved.
REQ-018 In NEG_HI, acc_hi SHALL become ~acc_hi + saved carry through the shared adder; the block then goes to FIN.
REQ-019 product SHALL be loaded with {acc_hi,acc_lo} on the edge entering FIN, and SHALL not change otherwise.
REQ-020 Latency: if start is sampled at edge k, done SHALL be high in the cycle after edge k+32 when no negation is needed, and after edge k+34 when negation is needed.
REQ-021 start while busy=1 SHALL be ignored, with no state or operand change.
REQ-022 start in the FIN cycle SHALL be accepted back-to-back; done is still high that cycle, and the block goes to CALC.
REQ-023 Without start, FIN SHALL return to IDLE after one cycle; done SHALL never be high for two consecutive cycles unless start is accepted in FIN.
REQ-024 A zero operand SHALL still take the full 32 CALC cycles and give product 0; neg_flag SHALL be forced to 0 when either operand is 0.
REQ-025 All 32-bit additions SHALL use the shared 32-bit adder instance; no other adder SHALL be inferred for accumulation.

Reset
REQ-026 When rst=1 at an edge: state=IDLE, busy=0, done=0, product=0, count=0, and all accumulators/flags=0.
REQ-027 rst SHALL take priority over start and abort any multiply in progress; no done pulse SHALL follow the aborted operation.
REQ-028 The first start SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, CALC, NEG_LO, NEG_HI, FIN), XLEN=32 and the CALC iteration count of 32.
REQ-030 One sub-module SHALL be instantiated: the team's 32-bit carry-lookahead adder (cla32, ports a, b, c_in, sum, carry-out).
REQ-031 The cla32 operand muxes SHALL be driven from the FSM state.
REQ-032 No other sub-modules SHALL be used.

Verification
REQ-033 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> product 0xFFFFFFFE_00000001, done exactly 33 cycles after start.
REQ-034 Signed -3 x 5 (0xFFFFFFFD, 0x00000005) -> product 0xFFFFFFFF_FFFFFFF1, done 35 cycles after start.
REQ-035 Signed 0x80000000 x 0x80000000 -> product 0x40000000_00000000, done 33 cycles after start; signed -1 x -1 -> product 1.
REQ-036 Back-to-back: start asserted in the FIN cycle with 7 x 6 unsigned -> second done 33 cycles later with product 42; the first product is held until then.
REQ-037 start pulsed at CALC count 10 -> ignored; the original result is unchanged.
REQ-038 rst at CALC count 20 -> next cycle busy=0, done=0, product=0; no done pulse follows.
REQ-039 Random compare: 10k random op_a/op_b/is_signed against a 64-bit reference model, checking product and latency.
